// File: rtl/led_ctrl.sv
// Two-channel LED controller: per-LED OFF/ON/BLINK/PULSE sequencer on a shared tick timebase,
// global PWM dimming and polarity inversion, register readback.
module led_ctrl #(
  parameter int unsigned CLK_FREQ = 80000000,
  parameter int unsigned TICK_HZ  = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        led1,
  output logic        led2,
  output logic [1:0]  busy,
  output logic [1:0]  done
);

  localparam int unsigned TICK_DIV = CLK_FREQ / TICK_HZ;
  localparam int unsigned PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] ModeOff   = 2'd0;
  localparam logic [1:0] ModeOn    = 2'd1;
  localparam logic [1:0] ModePulse = 2'd3;

  typedef enum logic [1:0] {S_OFF, S_ON, S_HI, S_LO} state_e;

  logic [PW-1:0]       presc_q;
  logic                tick;
  logic [7:0]          pwm_q;
  logic [7:0]          duty_q;
  logic                inv_q;

  logic [1:0][1:0]     mode_q, mode_d;
  logic [1:0][7:0]     num_q, num_d;
  logic [1:0][15:0]    hp_q, hp_d;
  state_e [1:0]        state_q, state_d;
  logic [1:0][15:0]    phase_q, phase_d;
  logic [1:0][7:0]     pcnt_q, pcnt_d;
  logic [1:0]          done_d, done_q;
  logic [1:0]          on;

  // Last phase value of a half-period; HP=0 behaves as HP=1.
  function automatic logic [15:0] hp_last(input logic [15:0] hp);
    return (hp == 16'd0) ? 16'd0 : hp - 16'd1;
  endfunction

  function automatic logic [31:0] cfg_word(input logic [1:0] m, input logic [7:0] n,
                                           input logic [15:0] hp);
    return {hp, n, 6'd0, m};
  endfunction

  assign tick = (presc_q == PW'(TICK_DIV - 1));

  // Free-running prescaler and PWM counter; never touched by register writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      pwm_q   <= '0;
    end else begin
      presc_q <= tick ? '0 : presc_q + PW'(1);
      pwm_q   <= pwm_q + 8'd1;
    end
  end

  // GLOBAL register: duty and output polarity.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      duty_q <= 8'hFF;
      inv_q  <= 1'b0;
    end else if (wr_en && addr == 2'd2) begin
      duty_q <= wdata[7:0];
      inv_q  <= wdata[8];
    end
  end

  // Per-LED sequencer next state; a CFG write wins over a coincident tick.
  always_comb begin
    mode_d  = mode_q;
    num_d   = num_q;
    hp_d    = hp_q;
    state_d = state_q;
    phase_d = phase_q;
    pcnt_d  = pcnt_q;
    done_d  = '0;
    for (int i = 0; i < 2; i++) begin
      if (wr_en && addr == 2'(i)) begin
        mode_d[i]  = wdata[1:0];
        num_d[i]   = wdata[15:8];
        hp_d[i]    = wdata[31:16];
        phase_d[i] = '0;
        pcnt_d[i]  = '0;
        unique case (wdata[1:0])
          ModeOff: state_d[i] = S_OFF;
          ModeOn:  state_d[i] = S_ON;
          default: begin
            if (wdata[1:0] == ModePulse && wdata[15:8] == 8'd0) begin
              // Zero-length pulse train completes immediately.
              state_d[i] = S_OFF;
              mode_d[i]  = ModeOff;
              done_d[i]  = 1'b1;
            end else begin
              state_d[i] = S_HI;
            end
          end
        endcase
      end else if (tick && (state_q[i] == S_HI || state_q[i] == S_LO)) begin
        if (phase_q[i] == hp_last(hp_q[i])) begin
          phase_d[i] = '0;
          if (state_q[i] == S_HI) begin
            state_d[i] = S_LO;
          end else if (mode_q[i] == ModePulse && (pcnt_q[i] + 8'd1) == num_q[i]) begin
            state_d[i] = S_OFF;
            mode_d[i]  = ModeOff;
            pcnt_d[i]  = '0;
            done_d[i]  = 1'b1;
          end else begin
            state_d[i] = S_HI;
            if (mode_q[i] == ModePulse) pcnt_d[i] = pcnt_q[i] + 8'd1;
          end
        end else begin
          phase_d[i] = phase_q[i] + 16'd1;
        end
      end
    end
  end

  // Sequencer and CFG state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q  <= '0;
      num_q   <= '0;
      hp_q    <= '0;
      state_q <= {S_OFF, S_OFF};
      phase_q <= '0;
      pcnt_q  <= '0;
      done_q  <= '0;
    end else begin
      mode_q  <= mode_d;
      num_q   <= num_d;
      hp_q    <= hp_d;
      state_q <= state_d;
      phase_q <= phase_d;
      pcnt_q  <= pcnt_d;
      done_q  <= done_d;
    end
  end

  // Logical LED level: lit states gated by PWM duty.
  always_comb begin
    on = '0;
    for (int i = 0; i < 2; i++) begin
      on[i] = (state_q[i] == S_ON || state_q[i] == S_HI) && (pwm_q <= duty_q);
    end
  end

  // Registered pin drives with polarity applied.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led1 <= 1'b0;
      led2 <= 1'b0;
    end else begin
      led1 <= on[0] ^ inv_q;
      led2 <= on[1] ^ inv_q;
    end
  end

  // Status outputs.
  always_comb begin
    busy = '0;
    for (int i = 0; i < 2; i++) begin
      busy[i] = (state_q[i] == S_HI || state_q[i] == S_LO);
    end
    done = done_q;
  end

  // Combinational register readback.
  always_comb begin
    rdata = '0;
    case (addr)
      2'd0:    rdata = cfg_word(mode_q[0], num_q[0], hp_q[0]);
      2'd1:    rdata = cfg_word(mode_q[1], num_q[1], hp_q[1]);
      2'd2:    rdata = {23'd0, inv_q, duty_q};
      default: rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_led_ctrl.sv
// Directed bench for led_ctrl with TICK_DIV=10 (one tick every 10 clk).
module tb_led_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        led1, led2;
  logic [1:0]  busy, done;

  int n_cmp = 0;
  int n_err = 0;
  int ecnt;

  led_ctrl #(.CLK_FREQ(1000), .TICK_HZ(100)) dut (
    .clk   (clk),
    .reset (reset),
    .wr_en (wr_en),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .led1  (led1),
    .led2  (led2),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Edges since reset release; equals the DUT prescaler value modulo 10.
  always @(posedge clk or negedge reset) begin
    if (!reset) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the write is captured on the next posedge, returns at the following negedge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    wr_en = 1'b1;
    addr  = a;
    wdata = d;
    @(negedge clk);
    wr_en = 1'b0;
    wdata = '0;
  endtask

  // Write so that the capturing edge is also a tick edge.
  task automatic wr_on_tick(input logic [1:0] a, input logic [31:0] d);
    for (int k = 0; k < 12 && (ecnt % 10) != 9; k++) @(negedge clk);
    wr(a, d);
  endtask

  task automatic rd_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, rdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   errs, errs2, cnt;
    logic exp;

    reset = 1'b0;
    wr_en = 1'b0;
    addr  = '0;
    wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_led1", led1, 0);
    check("rst_led2", led2, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rd_check("rst_cfg1", 2'd0, 32'h0);
    rd_check("rst_cfg2", 2'd1, 32'h0);
    rd_check("rst_global", 2'd2, 32'h0000_00FF);
    reset = 1'b1;
    @(negedge clk);

    // Address 3 is inert.
    wr(2'd3, 32'hFFFF_FFFF);
    rd_check("addr3_read", 2'd3, 32'h0);
    rd_check("addr3_no_global", 2'd2, 32'h0000_00FF);

    // ON: pin follows one clk after the state change.
    wr(2'd0, 32'h0000_0001);
    check("on_latency", led1, 0);
    @(negedge clk);
    check("on_led1", led1, 1);
    check("on_led2", led2, 0);
    check("on_busy", busy, 0);
    rd_check("on_cfg1", 2'd0, 32'h0000_0001);

    // PWM duty 63 with invert: 64 low clocks per 256.
    wr(2'd2, 32'h0000_013F);
    rd_check("pwm_global", 2'd2, 32'h0000_013F);
    repeat (2) @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (led1 == 1'b0) cnt++;
    end
    check("pwm_low_count", cnt, 64);
    wr(2'd2, 32'h0000_00FF);
    repeat (2) @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (led1 == 1'b1) cnt++;
    end
    check("pwm_full_count", cnt, 256);

    // BLINK HP=3 on LED2, aligned to a tick: 30 high, 30 low, 30 high.
    wr_on_tick(2'd1, 32'h0003_0002);
    check("blink_busy0", busy, 2'b10);
    errs  = 0;
    errs2 = 0;
    for (int i = 1; i <= 90; i++) begin
      @(negedge clk);
      exp = (i <= 30) || (i > 60);
      if (led2 !== exp) errs++;
      if (busy[1] !== 1'b1) errs2++;
    end
    check("blink_led2", errs, 0);
    check("blink_busy", errs2, 0);
    wr(2'd1, 32'h0);
    check("blink_stop_busy", busy, 2'b00);

    // PULSE HP=2 N=2 on LED1; write on a tick edge so the tick is discarded.
    wr_on_tick(2'd0, 32'h0002_0203);
    check("pulse_busy0", busy, 2'b01);
    errs  = 0;
    errs2 = 0;
    for (int i = 1; i <= 81; i++) begin
      @(negedge clk);
      exp = (i <= 20) || (i > 40 && i <= 60);
      if (led1 !== exp) errs++;
      if (done !== ((i == 80) ? 2'b01 : 2'b00)) errs2++;
      if (i == 79) check("pulse_busy79", busy, 2'b01);
      if (i == 80) begin
        check("pulse_busy_end", busy, 2'b00);
        rd_check("pulse_cfg1", 2'd0, 32'h0002_0200);
      end
    end
    check("pulse_led1", errs, 0);
    check("pulse_done", errs2, 0);

    // PULSE with N=0 finishes immediately.
    wr(2'd1, 32'h0001_0003);
    check("n0_done", done, 2'b10);
    check("n0_busy", busy, 2'b00);
    rd_check("n0_cfg2", 2'd1, 32'h0001_0000);
    @(negedge clk);
    check("n0_done_clr", done, 2'b00);

    // Reset in the middle of a pulse train.
    wr(2'd0, 32'h0002_0203);
    repeat (25) @(negedge clk);
    check("mid_busy", busy, 2'b01);
    reset = 1'b0;
    #1;
    check("mid_rst_led1", led1, 0);
    check("mid_rst_led2", led2, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    rd_check("mid_rst_cfg1", 2'd0, 32'h0);
    rd_check("mid_rst_global", 2'd2, 32'h0000_00FF);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    errs = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done !== 2'b00 || led1 !== 1'b0 || busy !== 2'b00) errs++;
    end
    check("mid_rst_quiet", errs, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/led_ctrl.md
LED_CTRL -- requirements
Module: led_ctrl

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 80000000, system clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 1000, timebase tick rate in Hz; TICK_DIV = CLK_FREQ/TICK_HZ, which SHALL be >= 2.
REQ-003 SHALL have port clk, input, 1, single system clock; all logic on posedge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset (reset=0 asserts).
REQ-005 SHALL have port wr_en, input, 1, register write strobe, one cycle per write.
REQ-006 SHALL have port addr, input, 2, register select for writes and reads.
REQ-007 SHALL have port wdata, input, 32, write data.
REQ-008 SHALL have port rdata, output, 32, combinational readback of the register at addr.
REQ-009 SHALL have ports led1 and led2, output, 1 each, registered LED drives.
REQ-010 SHALL have port busy, output, 2, bit i high while LED i+1 is in BLINK or PULSE mode.
REQ-011 SHALL have port done, output, 2, bit i is a one-cycle pulse when the PULSE sequence of LED i+1 completes.

Function
REQ-012 Registers SHALL be:
- addr0 = CFG1 (LED1); addr1 = CFG2 (LED2).
- CFG layout: [1:0] mode (0 OFF, 1 ON, 2 BLINK, 3 PULSE), [15:8] pulse count N, [31:16] half-period HP in ticks; other bits read 0.
- addr2 = GLOBAL: [7:0] duty, [8] invert.
- addr3 SHALL ignore writes and read 0.
REQ-013 The prescaler SHALL count 0..TICK_DIV-1 freely and assert an internal tick for one clk when at TICK_DIV-1, then wrap to 0.
REQ-014 Each LED SHALL have an FSM with states S_OFF, S_ON, S_HI, S_LO and a 16-bit phase counter and an 8-bit pulse counter.
REQ-015 A CFG write SHALL take effect the next cycle and SHALL clear the phase and pulse counters; the prescaler SHALL NOT be reset by writes.
- mode 0 -> S_OFF
- mode 1 -> S_ON
- mode 2 or 3 -> S_HI
REQ-016 In S_HI/S_LO, each tick SHALL increment the phase counter; on a tick with phase == HP_eff-1 the phase SHALL clear and the state SHALL toggle. HP_eff = max(HP,1).
REQ-017 In PULSE mode, each S_LO->S_HI transition SHALL increment the pulse counter. On the S_LO expiry where the count reaches N, the FSM SHALL instead:
- go to S_OFF
- clear the mode field to 0
- pulse done for one cycle
REQ-018 A PULSE write with N=0 SHALL go directly to S_OFF with mode cleared, and done SHALL pulse on the cycle after the write.
REQ-019 A write to a CFG on the same cycle as a tick SHALL take priority: the tick is discarded for that LED.
REQ-020 A GLOBAL write SHALL NOT disturb the FSM state or the counters.
REQ-021 An 8-bit free-running pwm_cnt SHALL increment every clk. Logical on = (S_ON or S_HI) and pwm_cnt <= duty, so duty=255 means always lit.
REQ-022 Each LED output SHALL be registered as led = on XOR invert, giving one clk latency from the FSM state to the pin.
REQ-023 busy[i] SHALL be high exactly while the FSM of LED i+1 is in S_HI or S_LO.

Reset
REQ-024 While reset=0, all state SHALL asynchronously take these values:
- CFG1 = CFG2 = 0
- duty = 255, invert = 0
- FSMs in S_OFF
- all counters 0
- led1 = led2 = 0, busy = 0, done = 0
REQ-025 Reset asserted mid-sequence SHALL abort that sequence with no done pulse. Operation SHALL resume on the first clk edge after reset=1.

Verification (sim with CLK_FREQ=1000, TICK_HZ=100, so TICK_DIV=10)
REQ-026 Reset: hold reset=0 for 3 clk -> led1=led2=0, busy=00, done=00, rdata=0 at addr0/1, rdata=0x000000FF at addr2.
REQ-027 ON: write CFG1=0x00000001 -> led1=1 from the second clk after the write; led2 stays 0.
REQ-028 BLINK: write CFG2=0x00030002 (HP=3) -> led2 high for 30 clk, then low for 30 clk, repeating; busy[1]=1 throughout.
REQ-029 PULSE: write CFG1=0x00020203 (HP=2, N=2) -> two 20-clk high/20-clk low pulses, then done[0] high for exactly 1 clk, busy[0]=0, CFG1 reads 0x00020200.
REQ-030 PWM and invert: write GLOBAL=0x0000013F with LED1 ON -> led1 low for 64 of every 256 clk; write GLOBAL=0x000000FF -> led1 steady high.
REQ-031 Boundaries:
- a CFG write coincident with a tick restarts the phase count from 0
- a PULSE write with N=0 gives done on the next cycle
- reset=0 mid-PULSE returns outputs to reset values with no done pulse
